// File: rtl/a_seq_pkg.sv
// a_seq_pkg: shared definitions for the A-pattern sequence generator.
//   LEN_W_DEFAULT - default width of the phase-length field
//   state_t       - sequencer state encoding (IDLE=0, PH1..PH4=1..4)
//   pattern_level - level of the A line for a given state
package a_seq_pkg;

    localparam int unsigned LEN_W_DEFAULT = 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PH1  = 3'd1,
        PH2  = 3'd2,
        PH3  = 3'd3,
        PH4  = 3'd4
    } state_t;

    // PH1 and PH3 drive A high, every other state drives it low.
    function automatic logic pattern_level(input state_t s);
        return (s == PH1) || (s == PH3);
    endfunction

endpackage

// File: rtl/phase_cnt.sv
// phase_cnt: loadable down-counter that times one phase of the sequence.
//   clk      - rising-edge clock
//   rst      - asynchronous active-high reset, clears the count
//   load     - load load_val this edge (takes priority over counting)
//   load_val - value loaded into the counter
//   zero     - high while the count is zero (last cycle of a phase)
// The count stops at zero instead of wrapping, so the all-ones length
// gives exactly 2^LEN_W cycles per phase.
module phase_cnt #(
    parameter int unsigned LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [LEN_W-1:0] load_val,
    output logic             zero
);

    logic [LEN_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/a_seq_gen.sv
// a_seq_gen: generates the four-phase pattern 1,0,1,0 on A, each phase
// lasting Len+1 cycles, and checks the detector's acknowledges.
//   Clock - rising-edge clock
//   Reset - asynchronous active-high reset
//   Go    - start request, accepted in IDLE or on the last PH4 cycle
//   Len   - per-phase hold count, latched when Go is accepted
//   K2    - Stop-to-Clear acknowledge, expected during PH3
//   K1    - Clear-to-Idle acknowledge, expected during PH4
//   A     - registered pattern line
//   Busy  - high whenever the sequencer is not in IDLE
//   Done  - one-cycle pulse when a sequence completes
//   Err   - sticky acknowledge error, cleared by the next accepted Go
module a_seq_gen
    import a_seq_pkg::*;
#(
    parameter int unsigned LEN_W = LEN_W_DEFAULT
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Go,
    input  logic [LEN_W-1:0] Len,
    input  logic             K2,
    input  logic             K1,
    output logic             A,
    output logic             Busy,
    output logic             Done,
    output logic             Err
);

    state_t           state;
    state_t           state_n;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_n;
    logic [LEN_W-1:0] load_val;
    logic             load;
    logic             cnt_zero;
    logic             done_n;
    logic             err_set;
    logic             err_clr;
    logic             a_n;
    logic             k2_seen;
    logic             k1_seen;

    phase_cnt #(
        .LEN_W (LEN_W)
    ) u_phase_cnt (
        .clk      (Clock),
        .rst      (Reset),
        .load     (load),
        .load_val (load_val),
        .zero     (cnt_zero)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        load     = 1'b0;
        load_val = len_q;
        len_n    = len_q;
        done_n   = 1'b0;
        err_set  = 1'b0;
        err_clr  = 1'b0;

        case (state)
            IDLE: begin
                if (Go) begin
                    state_n  = PH1;
                    load     = 1'b1;
                    load_val = Len;
                    len_n    = Len;
                    err_clr  = 1'b1;
                end
            end
            PH1: begin
                if (cnt_zero) begin
                    state_n = PH2;
                    load    = 1'b1;
                end
            end
            PH2: begin
                if (cnt_zero) begin
                    state_n = PH3;
                    load    = 1'b1;
                end
            end
            PH3: begin
                if (cnt_zero) begin
                    state_n = PH4;
                    load    = 1'b1;
                    if (!(k2_seen || K2)) begin
                        err_set = 1'b1;
                    end
                end
            end
            PH4: begin
                if (cnt_zero) begin
                    done_n = 1'b1;
                    if (!(k1_seen || K1)) begin
                        err_set = 1'b1;
                    end
                    // A held Go restarts straight from PH4 so back-to-back
                    // sequences have no idle gap; Done still pulses once.
                    if (Go) begin
                        state_n  = PH1;
                        load     = 1'b1;
                        load_val = Len;
                        len_n    = Len;
                        err_clr  = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // An acknowledge outside its own phase is a protocol error.
        if (K2 && (state != PH3)) begin
            err_set = 1'b1;
        end
        if (K1 && (state != PH4)) begin
            err_set = 1'b1;
        end

        a_n = pattern_level(state_n);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            len_q   <= '0;
            A       <= 1'b0;
            Done    <= 1'b0;
            Err     <= 1'b0;
            k2_seen <= 1'b0;
            k1_seen <= 1'b0;
        end else begin
            len_q   <= len_n;
            A       <= a_n;
            Done    <= done_n;
            // An error raised by the finishing sequence survives a restart
            // on the same edge so it is not silently lost.
            Err     <= (err_clr ? 1'b0 : Err) | err_set;
            k2_seen <= (state == PH3) && (k2_seen || K2);
            k1_seen <= (state == PH4) && (k1_seen || K1);
        end
    end

    assign Busy = (state != IDLE);

endmodule

// File: tb/tb_a_seq_gen.sv
module tb_a_seq_gen;

    localparam int LW = 4;

    logic          Clock = 1'b0;
    logic          Reset;
    logic          Go;
    logic [LW-1:0] Len;
    logic          K2;
    logic          K1;
    logic          A;
    logic          Busy;
    logic          Done;
    logic          Err;

    a_seq_gen #(
        .LEN_W (LW)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .Go    (Go),
        .Len   (Len),
        .K2    (K2),
        .K1    (K1),
        .A     (A),
        .Busy  (Busy),
        .Done  (Done),
        .Err   (Err)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic a;
        logic busy;
        logic done;
        logic err;
    } exp_t;

    exp_t  sb[$];
    int    checks = 0;
    int    errors = 0;
    string scen = "rst";

    // Behavioural reference of the sequencer.
    int    ms = 0;
    int    mc = 0;
    int    ml = 0;
    logic  me = 1'b0;
    logic  seen2 = 1'b0;
    logic  seen1 = 1'b0;

    // Detector model: acknowledges in the first cycle of PH3 / PH4.
    logic  det_k2 = 1'b1;
    logic  det_k1 = 1'b1;

    logic  oA, oB, oD, oE;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s observed=%0h expected=%0h", scen, tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ms = 0; mc = 0; ml = 0;
        me = 1'b0; seen2 = 1'b0; seen1 = 1'b0;
        sb.delete();
    endtask

    // Drive one cycle of inputs, predict the outputs after the next edge,
    // then sample on the falling edge and compare with the scoreboard.
    task automatic step(input logic go, input logic [LW-1:0] len,
                        input logic k2x, input logic k1x);
        logic k2v, k1v, set, clr, nd;
        int   ns, nc;
        exp_t e;
        k2v = k2x | (det_k2 && ms == 3 && mc == ml);
        k1v = k1x | (det_k1 && ms == 4 && mc == ml);
        Go = go; Len = len; K2 = k2v; K1 = k1v;

        set = 1'b0; clr = 1'b0; nd = 1'b0;
        ns = ms; nc = mc;
        if (k2v && ms != 3) set = 1'b1;
        if (k1v && ms != 4) set = 1'b1;
        if (ms == 0) begin
            if (go) begin ns = 1; nc = int'(len); ml = int'(len); clr = 1'b1; end
        end else if (mc == 0) begin
            if (ms == 3 && !(seen2 || k2v)) set = 1'b1;
            if (ms == 4 && !(seen1 || k1v)) set = 1'b1;
            if (ms < 4) begin
                ns = ms + 1; nc = ml;
            end else begin
                nd = 1'b1;
                if (go) begin ns = 1; nc = int'(len); ml = int'(len); clr = 1'b1; end
                else begin ns = 0; nc = 0; end
            end
        end else begin
            nc = mc - 1;
        end
        seen2 = (ms == 3) ? (seen2 | k2v) : 1'b0;
        seen1 = (ms == 4) ? (seen1 | k1v) : 1'b0;
        me = (clr ? 1'b0 : me) | set;
        ms = ns; mc = nc;
        e.a = (ms == 1 || ms == 3);
        e.busy = (ms != 0);
        e.done = nd;
        e.err = me;
        sb.push_back(e);

        @(posedge Clock);
        @(negedge Clock);
        e = sb.pop_front();
        oA = A; oB = Busy; oD = Done; oE = Err;
        chk("a", 32'(A), 32'(e.a));
        chk("busy", 32'(Busy), 32'(e.busy));
        chk("done", 32'(Done), 32'(e.done));
        chk("err", 32'(Err), 32'(e.err));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [13:0] ahist;
        logic [7:0]  a8;
        int          bcnt, dcnt, dat;

        Reset = 1'b1; Go = 1'b0; Len = '0; K2 = 1'b0; K1 = 1'b0;
        model_reset();
        @(negedge Clock);
        chk("a", 32'(A), 32'd0);
        chk("busy", 32'(Busy), 32'd0);
        chk("done", 32'(Done), 32'd0);
        chk("err", 32'(Err), 32'd0);
        Reset = 1'b0;

        // Len=2 single pulse: 12 busy cycles, Done in cycle 13.
        scen = "len2";
        ahist = '0; bcnt = 0; dat = 0;
        for (int i = 1; i <= 14; i++) begin
            step(i == 1, 4'd2, 1'b0, 1'b0);
            ahist = {ahist[12:0], oA};
            if (oB) bcnt++;
            if (oD && dat == 0) dat = i;
        end
        chk("apat", 32'(ahist[13:2]), 32'b111000111000);
        chk("bcnt", 32'(bcnt), 32'd12);
        chk("doneat", 32'(dat), 32'd13);
        chk("errend", 32'(oE), 32'd0);

        // Len=0, Go held 10 cycles: back-to-back with no gap.
        scen = "len0";
        a8 = '0; bcnt = 0; dcnt = 0;
        for (int i = 1; i <= 13; i++) begin
            step(i <= 10, 4'd0, 1'b0, 1'b0);
            if (i <= 8) a8 = {a8[6:0], oA};
            if (i <= 12 && oB) bcnt++;
            if (oD) dcnt++;
        end
        chk("apat", 32'(a8), 32'b10101010);
        chk("bcnt", 32'(bcnt), 32'd12);
        chk("dcnt", 32'(dcnt), 32'd3);

        // Len=1, K1 never returned: Err in first IDLE cycle, next Go clears.
        scen = "nok1";
        det_k1 = 1'b0;
        for (int i = 1; i <= 9; i++) step(i == 1, 4'd1, 1'b0, 1'b0);
        chk("idledone", 32'(oD), 32'd1);
        chk("idleerr", 32'(oE), 32'd1);
        det_k1 = 1'b1;
        step(1'b1, 4'd1, 1'b0, 1'b0);
        chk("errclr", 32'(oE), 32'd0);
        for (int i = 2; i <= 9; i++) step(1'b0, 4'd1, 1'b0, 1'b0);
        chk("errend", 32'(oE), 32'd0);

        // Stray K2 in PH1: Err next edge, sequence still 8 cycles.
        scen = "k2ph1";
        bcnt = 0;
        step(1'b1, 4'd1, 1'b0, 1'b0);
        if (oB) bcnt++;
        step(1'b0, 4'd1, 1'b1, 1'b0);
        if (oB) bcnt++;
        chk("errset", 32'(oE), 32'd1);
        for (int i = 3; i <= 10; i++) begin
            step(1'b0, 4'd1, 1'b0, 1'b0);
            if (oB) bcnt++;
        end
        chk("bcnt", 32'(bcnt), 32'd8);
        chk("errsticky", 32'(oE), 32'd1);

        // Reset in second PH2 cycle with Len=3: immediate, no Done.
        scen = "reset";
        for (int i = 1; i <= 6; i++) step(i == 1, 4'd3, 1'b0, 1'b0);
        chk("inph2", 32'(oA), 32'd0);
        chk("busyph2", 32'(oB), 32'd1);
        Reset = 1'b1;
        #1;
        chk("a_async", 32'(A), 32'd0);
        chk("busy_async", 32'(Busy), 32'd0);
        chk("done_async", 32'(Done), 32'd0);
        chk("err_async", 32'(Err), 32'd0);
        model_reset();
        @(negedge Clock);
        Reset = 1'b0;
        dcnt = 0;
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 4'd3, 1'b0, 1'b0);
            if (oD) dcnt++;
        end
        chk("nodone", 32'(dcnt), 32'd0);

        // Go during PH3 and Len 2->7 mid-sequence: no effect.
        scen = "ignore";
        ahist = '0; dcnt = 0;
        for (int i = 1; i <= 16; i++) begin
            step((i == 1) || (i == 8), (i <= 2) ? 4'd2 : 4'd7, 1'b0, 1'b0);
            if (i <= 12) ahist = {ahist[12:0], oA};
            if (oD) dcnt++;
        end
        chk("apat", 32'(ahist[11:0]), 32'b111000111000);
        chk("dcnt", 32'(dcnt), 32'd1);
        chk("errend", 32'(oE), 32'd0);

        // Maximum Len: 16 cycles per phase, no wrap.
        scen = "lenmax";
        bcnt = 0; dcnt = 0;
        for (int i = 1; i <= 66; i++) begin
            step(i == 1, 4'hF, 1'b0, 1'b0);
            if (oB) bcnt++;
            if (oD) dcnt++;
        end
        chk("bcnt", 32'(bcnt), 32'd64);
        chk("dcnt", 32'(dcnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
